// File: rtl/imem_loader_pkg.sv
// loader_pkg: shared definitions for the instruction-memory loader.
//
// Contents:
//   state_t        loader frame-parser states
//   DEFAULT_DEPTH  default instruction memory capacity in 32-bit words
//   HEADER_BYTES   bytes in the frame header (16-bit little-endian word count)
//   WORD_BYTES     bytes per instruction word
//   LEN_W          width of the word-count field in the header
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0 = 3'd0,  // waiting for word count, low byte
    LEN1 = 3'd1,  // waiting for word count, high byte
    DATA = 3'd2,  // receiving payload bytes
    CSUM = 3'd3,  // waiting for the checksum byte
    DONE = 3'd4,  // image loaded and verified (sticky)
    ERR  = 3'd5   // framing or checksum failure (sticky)
  } state_t;

  localparam int DEFAULT_DEPTH = 256;
  localparam int HEADER_BYTES  = 2;
  localparam int WORD_BYTES    = 4;
  localparam int LEN_W         = 8 * HEADER_BYTES;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words.
//
// Each accepted byte lands in the next lane (0..3). The lane-3 byte is not
// stored: the completed word is presented combinationally in the same cycle
// that lane 3 is accepted, together with word_last, so the consumer can
// register it without an extra cycle of latency.
//
// Ports:
//   clk        clock, rising edge
//   srst       synchronous active-high reset (clears lane counter and bytes)
//   byte_en    a byte is accepted this cycle
//   byte_in    the byte being accepted
//   word_last  byte_en on lane 3: word is complete this cycle
//   word       assembled word {byte_in, lane2, lane1, lane0}
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_last,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  logic [1:0] lane_reg;

  assign word_last = byte_en && (lane_reg == LAST_LANE);

  // Lane counter wraps naturally from 3 back to 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      lane_reg <= '0;
    end else if (byte_en) begin
      lane_reg <= lane_reg + 2'd1;
    end
  end

  // Lower lanes hold their byte until the word completes.
  for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
    logic [7:0] byte_reg;

    always_ff @(posedge clk) begin
      if (srst) begin
        byte_reg <= '0;
      end else if (byte_en && (lane_reg == 2'(gi))) begin
        byte_reg <= byte_in;
      end
    end

    assign word[gi*8 +: 8] = byte_reg;
  end

  // Top lane comes straight from the input on the completing cycle.
  assign word[31:24] = byte_in;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Receives a program image as a byte stream over valid/ready:
//   N_lo, N_hi, N*4 payload bytes (little-endian words), checksum byte
// where the checksum is the XOR of the payload bytes only. Payload words are
// written to the instruction memory at byte addresses 0, 4, 8, ... and the
// core is held in reset until the whole image has arrived and verified.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   in_valid    byte on in_data is valid
//   in_data     stream byte
//   in_ready    loader can accept a byte this cycle
//   mem_we      one-cycle write strobe to the instruction memory
//   mem_addr    word-aligned byte address of the write
//   mem_wdata   instruction word
//   core_reset  high until the load completes successfully
//   done        image loaded and checksum matched (sticky)
//   error       framing or checksum failure (sticky)
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  // Index must be able to hold DEPTH itself (N = DEPTH is a legal image).
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [LEN_W:0] DEPTH_LIMIT = (LEN_W + 1)'(DEPTH);

  state_t state_reg;
  state_t state_next;

  logic [7:0]        len_lo_reg;
  logic [IDX_W-1:0]  count_reg;
  logic [IDX_W-1:0]  index_reg;
  logic [7:0]        csum_reg;

  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;

  logic              ready_state;
  logic              accept;
  logic              data_en;
  logic [LEN_W-1:0]  len_full;
  logic              len_oversize;
  logic              word_last;
  logic [31:0]       word;
  logic              last_word;

  // Ready in every receiving state; forced low while reset is asserted so
  // no byte can slip in on the reset edge.
  assign ready_state = (state_reg == LEN0) || (state_reg == LEN1) ||
                       (state_reg == DATA) || (state_reg == CSUM);
  assign in_ready    = ready_state && !reset;
  assign accept      = in_valid && in_ready;
  assign data_en     = accept && (state_reg == DATA);

  assign len_full     = {in_data, len_lo_reg};
  assign len_oversize = {1'b0, len_full} > DEPTH_LIMIT;
  assign last_word    = (index_reg + IDX_W'(1)) == count_reg;

  word_assembler u_word_assembler (
    .clk       (clock),
    .srst      (reset),
    .byte_en   (data_en),
    .byte_in   (in_data),
    .word_last (word_last),
    .word      (word)
  );

  // ---------------------------------------------------------------------------
  // Frame-parser FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LEN0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LEN0: begin
        if (accept) begin
          state_next = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          if (len_oversize) begin
            state_next = ERR;
          end else if (len_full == '0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (word_last && last_word) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          // The checksum register already holds the XOR of every payload byte.
          state_next = (in_data == csum_reg) ? DONE : ERR;
        end
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: header capture, checksum, write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      len_lo_reg    <= '0;
      count_reg     <= '0;
      index_reg     <= '0;
      csum_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_we_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          LEN0: len_lo_reg <= in_data;
          // Only meaningful when the count is legal; an oversize count goes
          // straight to ERR and is never used.
          LEN1: count_reg <= IDX_W'(len_full);
          DATA: begin
            csum_reg <= csum_reg ^ in_data;
            if (word_last) begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= ADDR_W'({index_reg, 2'b00});
              mem_wdata_reg <= word;
              index_reg     <= index_reg + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERR);
  // Core stays in reset for everything short of a verified image, including
  // after an error, so a partially written memory is never executed.
  assign core_reset = (state_reg != DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    int          nbytes;
    logic [7:0]  b [11];
    int          gap;
    int          nw;
    logic [31:0] w [2];
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  logic [31:0] last_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      n_writes++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", mem_wdata, e.data);
      end
      $display("write addr=%h data=%h", mem_addr, mem_wdata);
    end
  end

  // Reset for one cycle, check reset values while reset is still high,
  // then check that the loader becomes ready.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_core_reset", {31'b0, core_reset}, 32'h1);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", {31'b0, in_ready}, 32'h1);
  endtask

  // Offer one byte after `gap` idle cycles; returns on the negedge just
  // after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h in_ready=%b required 1", b, in_ready);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Called right after a lane-3 byte: the write must be on the bus now and
  // the loader must not stall.
  task automatic check_write_cycle();
    check("write_strobe", {31'b0, mem_we}, 32'h1);
    check("ready_during_write", {31'b0, in_ready}, 32'h1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0]  csum;
    logic [31:0] wd;
    logic [7:0]  nom[11];

    nom = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};

    vecs[0] = '{name:"nominal", nbytes:11, b:nom, gap:0, nw:2,
                w:'{32'h00500093, 32'h00108133}, exp_done:1'b1, exp_err:1'b0};
    vecs[1] = '{name:"empty_ok", nbytes:3, b:'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gap:0, nw:0, w:'{32'h0, 32'h0}, exp_done:1'b1, exp_err:1'b0};
    vecs[2] = '{name:"empty_bad", nbytes:3, b:'{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gap:0, nw:0, w:'{32'h0, 32'h0}, exp_done:1'b0, exp_err:1'b1};
    vecs[3] = '{name:"bad_csum", nbytes:11,
                b:'{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h60},
                gap:0, nw:2, w:'{32'h00500093, 32'h00108133}, exp_done:1'b0, exp_err:1'b1};
    vecs[4] = '{name:"oversize", nbytes:2, b:'{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gap:0, nw:0, w:'{32'h0, 32'h0}, exp_done:1'b0, exp_err:1'b1};
    vecs[5] = '{name:"valid_gaps", nbytes:11, b:nom, gap:3, nw:2,
                w:'{32'h00500093, 32'h00108133}, exp_done:1'b1, exp_err:1'b0};

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 6; v++) begin
      apply_reset();
      for (int i = 0; i < vecs[v].nw; i++) begin
        exp_q.push_back('{addr: 32'(i * 4), data: vecs[v].w[i]});
      end
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        send_byte(vecs[v].b[k], vecs[v].gap);
        if (k >= 2 && k < 2 + 4 * vecs[v].nw && ((k - 2) % 4) == 3) begin
          check_write_cycle();
        end
      end
      check({vecs[v].name, "_done"}, {31'b0, done}, {31'b0, vecs[v].exp_done});
      check({vecs[v].name, "_error"}, {31'b0, error}, {31'b0, vecs[v].exp_err});
      check({vecs[v].name, "_core_reset"}, {31'b0, core_reset}, {31'b0, ~vecs[v].exp_done});
      // Terminal states refuse further bytes.
      in_valid = 1'b1;
      in_data = 8'hA5;
      repeat (3) @(negedge clock);
      check({vecs[v].name, "_ready_terminal"}, {31'b0, in_ready}, 32'h0);
      check({vecs[v].name, "_sticky_done"}, {31'b0, done}, {31'b0, vecs[v].exp_done});
      in_valid = 1'b0;
      check({vecs[v].name, "_pending_writes"}, 32'(exp_q.size()), 32'h0);
      $display("frame %s: done=%b error=%b core_reset=%b writes_left=%0d",
               vecs[v].name, done, error, core_reset, exp_q.size());
    end

    // ---------------- full-depth image: N = DEPTH ----------------
    apply_reset();
    send_byte(8'(DEPTH), 0);
    send_byte(8'(DEPTH >> 8), 0);
    csum = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      exp_q.push_back('{addr: 32'(i * 4), data: wd});
      for (int l = 0; l < 4; l++) begin
        send_byte(wd[l*8 +: 8], 0);
        csum = csum ^ wd[l*8 +: 8];
      end
      if (i == 0 || i == DEPTH - 1) begin
        check_write_cycle();
      end
    end
    send_byte(csum, 0);
    check("full_done", {31'b0, done}, 32'h1);
    check("full_core_reset", {31'b0, core_reset}, 32'h0);
    check("full_last_addr", last_addr, 32'((DEPTH - 1) * 4));
    check("full_pending_writes", 32'(exp_q.size()), 32'h0);
    $display("frame full_depth: done=%b last_addr=%h", done, last_addr);

    // ---------------- reset mid-load ----------------
    apply_reset();
    // Four payload bytes complete word 0 before the abort; the fifth byte
    // sits in a partial word that must never reach memory.
    exp_q.push_back('{addr: 32'h0, data: 32'h00500093});
    for (int k = 0; k < 7; k++) begin
      send_byte(nom[k], 0);
    end
    check("abort_core_reset", {31'b0, core_reset}, 32'h1);
    apply_reset();
    check("abort_pending_writes", 32'(exp_q.size()), 32'h0);
    exp_q.push_back('{addr: 32'h0, data: 32'h00500093});
    exp_q.push_back('{addr: 32'h4, data: 32'h00108133});
    for (int k = 0; k < 11; k++) begin
      send_byte(nom[k], 0);
      if (k == 5 || k == 9) begin
        check_write_cycle();
      end
    end
    check("reload_done", {31'b0, done}, 32'h1);
    check("reload_error", {31'b0, error}, 32'h0);
    check("reload_core_reset", {31'b0, core_reset}, 32'h0);
    repeat (2) @(negedge clock);
    check("reload_pending_writes", 32'(exp_q.size()), 32'h0);
    $display("frame reload: done=%b error=%b", done, error);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
